lfsr_msg_encoder: RTL and testbench
===================================

// Module: lfsr_msg_encoder
// PURPOSE
//  Encrypting end of the Lab 5 LFSR cipher: reads a plaintext message from data memory,
//  prepends a run of space characters, XORs every byte with a selectable 8-bit LFSR keystream
//  and writes the 64-byte ciphertext to the upper half of memory, where the decoder consumes it.
//  Sits beside data memory as a single-port memory master, launched by start, reports done.
// PARAMETERS
//  SRC_BASE  0   first plaintext address read
//  DST_BASE  64  first ciphertext address written
//  MSG_LEN   64  ciphertext bytes written (preamble + message)
// PORTS
//  clk        in   1  clock, rising edge
//  init_n     in   1  asynchronous active-low reset
//  start      in   1  launch encode, sampled in IDLE/DONE only
//  tap_sel    in   3  feedback pattern: 0..7 = E1,D4,C6,B8,B4,B2,FA,F3
//  seed       in   8  initial LFSR state (keystream byte 0)
//  pre_len    in   4  leading spaces, saturated to 9..15
//  mem_addr   out  8  memory address
//  mem_wr_en  out  1  memory write strobe
//  mem_wdata  out  8  memory write data
//  mem_rdata  in   8  memory read data, valid the cycle after mem_addr is presented
//  busy       out  1  high from the cycle after start acceptance until done
//  done       out  1  high in DONE, held until next accepted start
// BEHAVIOUR
//  - Only clock: clk; reset: init_n, asynchronous, active-low. Reset: state=IDLE; busy,done,
//    mem_wr_en=0; mem_addr,mem_wdata=0; LFSR=0; counters=0. Reset mid-run aborts at once;
//    memory keeps whatever was written before reset.
//  - Accept: start=1 at an edge in IDLE or DONE latches tap_sel, seed (0 -> 8'h01 to avoid
//    lock-up), pre_len (<9 -> 9); out index i=0; L=seed; done clears; go PRE. start ignored
//    while busy.
//  - Keystream: L(i+1) = {L(i)[6:0], ^(L(i) & taps)}; byte i uses L(i); advances after each write.
//  - PRE (1 cycle/byte): mem_wr_en=1, addr=DST_BASE+i, wdata=SPACE^L(i); i++; after
//    i=pre_len-1 go RD.
//  - RD: mem_wr_en=0, addr=SRC_BASE+(i-pre_len); go WR.
//  - WR: mem_wr_en=1, addr=DST_BASE+i, wdata=P(mem_rdata)^L(i); i++; if i was MSG_LEN-1 go
//    DONE, else RD.
//  - DONE: busy=0, done=1, mem_wr_en=0; stays until start or reset.
//  - Latency: writes occupy cycles 1..(2*MSG_LEN-pre_len) after acceptance; done rises on the
//    next edge (pre_len=9: 119 work cycles). Source bytes read: MSG_LEN-pre_len; bytes beyond
//    them are never read.
//  - Width: i is 7-bit; addresses are 8-bit modulo 256, no wrap checks (param set must fit).
//  - mem_wdata only meaningful when mem_wr_en=1; exactly one write per output byte, never a
//    write to SRC range.
// CONFIGURATION
//  LFSR_ENC_PARITY_EN defined: SPACE=8'hA0; P(x)={^x[6:0], x[6:0]} (bit7 = even-parity bit
//    over bits 6:0 of each plaintext byte), matching the decoder's A0 preamble key recovery.
//  Not defined: SPACE=8'h20; P(x)=x unchanged.
// TESTING
//  1 tap_sel=0, seed=01, pre_len=9, no macro -> mem[64]=21, mem[65]=23, mem[66]=27;
//    done at cycle 119+1, busy low after.
//  2 Same with LFSR_ENC_PARITY_EN -> mem[64]=A1, mem[65]=A3; src byte 41 ('A') at 73 encodes
//    as 41^L(9).
//  3 seed=00, pre_len=3 -> behaves as seed=01, pre_len=9: mem[64..72]=spaces^key, first read
//    addr 0, first msg byte at 73.
//  4 init_n low at cycle 50 -> busy,done,mem_wr_en=0 same cycle; restart yields output
//    identical to uninterrupted run.
//  5 start pulsed every cycle while busy -> no restart, write count = 64, done once.
//  6 Round trip: random tap_sel/seed/pre_len, ASCII message -> decoder run restores message at
//    mem[0..]; foundit=tap_sel.

Source files
------------

// File: rtl/lfsr_msg_encoder.sv
// LFSR cipher encoder: reads plaintext from memory, prepends a space preamble, XORs every byte with
// an 8-bit LFSR keystream and writes the ciphertext upward. Optional macro: LFSR_ENC_PARITY_EN.
module lfsr_msg_encoder #(
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 64,
    parameter int MSG_LEN  = 64
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    input  logic [2:0] tap_sel,
    input  logic [7:0] seed,
    input  logic [3:0] pre_len,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] SRC_BASE_B = 8'(SRC_BASE);
    localparam logic [7:0] DST_BASE_B = 8'(DST_BASE);
    localparam logic [6:0] LAST_IDX   = 7'(MSG_LEN - 1);
    localparam logic [3:0] MIN_PRE    = 4'd9;

`ifdef LFSR_ENC_PARITY_EN
    // The decoder recovers the key from an A0 preamble, so spaces carry bit 7 set.
    localparam logic [7:0] SPACE = 8'hA0;

    function automatic logic [7:0] plain_map(input logic [7:0] x);
        return {^x[6:0], x[6:0]};
    endfunction
`else
    localparam logic [7:0] SPACE = 8'h20;

    function automatic logic [7:0] plain_map(input logic [7:0] x);
        return x;
    endfunction
`endif

    function automatic logic [7:0] tap_mask(input logic [2:0] sel);
        logic [7:0] m;
        case (sel)
            3'd0:    m = 8'hE1;
            3'd1:    m = 8'hD4;
            3'd2:    m = 8'hC6;
            3'd3:    m = 8'hB8;
            3'd4:    m = 8'hB4;
            3'd5:    m = 8'hB2;
            3'd6:    m = 8'hFA;
            default: m = 8'hF3;
        endcase
        return m;
    endfunction

    state_t     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] taps_q, taps_d;
    logic [3:0] pre_q, pre_d;

    logic [7:0] fb_terms;
    logic [7:0] lfsr_adv;
    logic [6:0] pre_last;
    logic [7:0] src_offset;
    logic       can_start;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fb
            assign fb_terms[gi] = lfsr_q[gi] & taps_q[gi];
        end
    endgenerate

    assign lfsr_adv   = {lfsr_q[6:0], ^fb_terms};
    assign pre_last   = {3'd0, pre_q} - 7'd1;
    assign src_offset = {1'b0, idx_q} - {4'd0, pre_q};
    assign can_start  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= S_IDLE;
            idx_q   <= 7'd0;
            lfsr_q  <= 8'd0;
            taps_q  <= 8'd0;
            pre_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        taps_d  = taps_q;
        pre_d   = pre_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (can_start) begin
                    state_d = S_PRE;
                    idx_d   = 7'd0;
                    // An all-zero seed would lock the LFSR, so it is promoted to 1.
                    lfsr_d  = (seed == 8'd0) ? 8'h01 : seed;
                    taps_d  = tap_mask(tap_sel);
                    pre_d   = (pre_len < MIN_PRE) ? MIN_PRE : pre_len;
                end
            end
            S_PRE: begin
                idx_d  = idx_q + 7'd1;
                lfsr_d = lfsr_adv;
                if (idx_q == pre_last) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                idx_d  = idx_q + 7'd1;
                lfsr_d = lfsr_adv;
                state_d = (idx_q == LAST_IDX) ? S_DONE : S_RD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        case (state_q)
            S_PRE: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = DST_BASE_B + {1'b0, idx_q};
                mem_wdata = SPACE ^ lfsr_q;
            end
            S_RD: begin
                busy     = 1'b1;
                mem_addr = SRC_BASE_B + src_offset;
            end
            S_WR: begin
                // mem_rdata answers the address presented during the preceding RD cycle.
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = DST_BASE_B + {1'b0, idx_q};
                mem_wdata = plain_map(mem_rdata) ^ lfsr_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lfsr_msg_encoder.sv
// Directed bench for lfsr_msg_encoder: behavioural memory, hand-computed ciphertext bytes,
// reset abort, start-while-busy and round-trip decoding. Honours LFSR_ENC_PARITY_EN.
module tb_lfsr_msg_encoder;

    logic       clk = 1'b0;
    logic       init_n;
    logic       start;
    logic [2:0] tap_sel;
    logic [7:0] seed;
    logic [3:0] pre_len;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    lfsr_msg_encoder dut (
        .clk       (clk),
        .init_n    (init_n),
        .start     (start),
        .tap_sel   (tap_sel),
        .seed      (seed),
        .pre_len   (pre_len),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

`ifdef LFSR_ENC_PARITY_EN
    localparam logic [7:0] SP = 8'hA0;
    function automatic logic [7:0] p_of(input logic [7:0] x);
        return {^x[6:0], x[6:0]};
    endfunction
`else
    localparam logic [7:0] SP = 8'h20;
    function automatic logic [7:0] p_of(input logic [7:0] x);
        return x;
    endfunction
`endif

    function automatic logic [7:0] tap_of(input logic [2:0] s);
        logic [7:0] m;
        case (s)
            3'd0: m = 8'hE1;  3'd1: m = 8'hD4;  3'd2: m = 8'hC6;  3'd3: m = 8'hB8;
            3'd4: m = 8'hB4;  3'd5: m = 8'hB2;  3'd6: m = 8'hFA;  default: m = 8'hF3;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] l, input logic [7:0] t);
        return {l[6:0], ^(l & t)};
    endfunction

    // Memory model with one-cycle read latency, plus bus activity monitors.
    logic [7:0] mem [0:255];
    logic [7:0] plain [0:63];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'd0;
    logic [7:0] tb_data = 8'd0;
    logic       mon_clr = 1'b0;
    int         wr_cnt, src_wr_cnt, rd_cnt, done_rise_cnt;
    logic [7:0] first_rd_addr;
    logic       done_prev = 1'b0;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        done_prev <= done;
        if (mon_clr) begin
            wr_cnt <= 0; src_wr_cnt <= 0; rd_cnt <= 0; done_rise_cnt <= 0;
            first_rd_addr <= 8'hFF;
        end else begin
            if (mem_wr_en) begin
                wr_cnt <= wr_cnt + 1;
                if (mem_addr < 8'd64) src_wr_cnt <= src_wr_cnt + 1;
            end
            if (busy && !mem_wr_en) begin
                if (rd_cnt == 0) first_rd_addr <= mem_addr;
                rd_cnt <= rd_cnt + 1;
            end
            if (done && !done_prev) done_rise_cnt <= done_rise_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_put(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        tick();
        tb_we = 1'b0;
    endtask

    // kind 0: "ABC..." alphabet; kind 1: random printable ASCII. Destination is cleared.
    task automatic load_msg(input int kind);
        for (int j = 0; j < 64; j++) begin
            plain[j] = (kind == 0) ? 8'(8'h41 + j % 26) : 8'($urandom_range(32, 126));
            mem_put(8'(j), plain[j]);
        end
        for (int j = 64; j < 128; j++) mem_put(8'(j), 8'h00);
    endtask

    task automatic launch(input logic [2:0] t, input logic [7:0] s, input logic [3:0] p);
        tap_sel = t; seed = s; pre_len = p;
        mon_clr = 1'b1; start = 1'b1;
        tick();
        mon_clr = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
        cycles = n;
    endtask

    task automatic verify_buffer(input string tag, input logic [2:0] t, input logic [7:0] s,
                                 input logic [3:0] p);
        logic [7:0] l;
        logic [7:0] e;
        int pe;
        l  = (s == 8'd0) ? 8'h01 : s;
        pe = (p < 4'd9) ? 9 : int'(p);
        for (int j = 0; j < 64; j++) begin
            e = ((j < pe) ? SP : p_of(plain[j - pe])) ^ l;
            check($sformatf("%s_byte%0d", tag, j), 32'(mem[64 + j]), 32'(e));
            l = step(l, tap_of(t));
        end
    endtask

    int cyc;
    logic [2:0] rt_tap [0:3];
    logic [7:0] rt_seed [0:3];
    logic [3:0] rt_pre [0:3];

    initial begin
        init_n = 1'b0; start = 1'b0; tap_sel = 3'd0; seed = 8'd0; pre_len = 4'd0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        tick();
        init_n = 1'b1;
        tick();

        // Basic run: tap E1, seed 01, nine spaces.
        load_msg(0);
        launch(3'd0, 8'h01, 4'd9);
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_done("t1", cyc);
        $display("run t1: tap=0 seed=01 pre=9 done after %0d cycles, %0d writes", cyc, wr_cnt);
        check("t1_cycles", 32'(cyc), 32'd119);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_writes", 32'(wr_cnt), 32'd64);
        check("t1_reads", 32'(rd_cnt), 32'd55);
        check("t1_first_rd", 32'(first_rd_addr), 32'd0);
        check("t1_src_writes", 32'(src_wr_cnt), 32'd0);
`ifdef LFSR_ENC_PARITY_EN
        check("t1_mem64", 32'(mem[64]), 32'hA1);
        check("t1_mem65", 32'(mem[65]), 32'hA3);
        check("t1_mem66", 32'(mem[66]), 32'hA7);
        check("t1_mem72", 32'(mem[72]), 32'h59);
`else
        check("t1_mem64", 32'(mem[64]), 32'h21);
        check("t1_mem65", 32'(mem[65]), 32'h23);
        check("t1_mem66", 32'(mem[66]), 32'h27);
        check("t1_mem72", 32'(mem[72]), 32'hD9);
`endif
        check("t1_mem73", 32'(mem[73]), 32'hB3);
        verify_buffer("t1", 3'd0, 8'h01, 4'd9);
        tick(); tick(); tick();
        check("t1_done_held", 32'(done), 32'd1);

        // Zero seed and short preamble saturate to seed 01, nine spaces.
        load_msg(0);
        launch(3'd0, 8'h00, 4'd3);
        wait_done("t3", cyc);
        $display("run t3: tap=0 seed=00 pre=3 done after %0d cycles", cyc);
        check("t3_cycles", 32'(cyc), 32'd119);
        check("t3_first_rd", 32'(first_rd_addr), 32'd0);
        check("t3_mem73", 32'(mem[73]), 32'hB3);
        verify_buffer("t3", 3'd0, 8'h01, 4'd9);

        // Asynchronous reset during cycle 50, then a clean rerun.
        load_msg(0);
        launch(3'd0, 8'h01, 4'd9);
        for (int k = 0; k < 49; k++) tick();
        #2 init_n = 1'b0;
        #1;
        $display("run t4: reset asserted in cycle 50 after %0d writes", wr_cnt);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("t4_rst_addr", 32'(mem_addr), 32'd0);
        check("t4_writes_before", 32'(wr_cnt), 32'd29);
        tick();
        init_n = 1'b1;
        tick();
        check("t4_kept_mem64", 32'(mem[64]), 32'(SP ^ 8'h01));
        check("t4_untouched_mem127", 32'(mem[127]), 32'h00);
        check("t4_idle_busy", 32'(busy), 32'd0);
        launch(3'd0, 8'h01, 4'd9);
        wait_done("t4", cyc);
        $display("run t4: rerun done after %0d cycles", cyc);
        check("t4_cycles", 32'(cyc), 32'd119);
        verify_buffer("t4", 3'd0, 8'h01, 4'd9);

        // start held high throughout the run with different config: must be ignored.
        load_msg(0);
        launch(3'd0, 8'h01, 4'd9);
        cyc = 0;
        while (!done && cyc < 400) begin
            start = 1'b1; tap_sel = 3'd5; seed = 8'h55; pre_len = 4'd14;
            tick();
            cyc++;
        end
        start = 1'b0;
        tick(); tick();
        $display("run t5: start held while busy, done after %0d cycles, %0d writes", cyc, wr_cnt);
        check("t5_cycles", 32'(cyc), 32'd119);
        check("t5_writes", 32'(wr_cnt), 32'd64);
        check("t5_done_rises", 32'(done_rise_cnt), 32'd1);
        check("t5_done_held", 32'(done), 32'd1);
        verify_buffer("t5", 3'd0, 8'h01, 4'd9);

        // Round trip: decode with the keystream and recover the message.
        rt_tap[0] = 3'd7; rt_seed[0] = 8'hFF; rt_pre[0] = 4'd15;
        rt_tap[1] = 3'd3; rt_seed[1] = 8'h80; rt_pre[1] = 4'd12;
        rt_tap[2] = 3'($urandom_range(0, 7)); rt_seed[2] = 8'($urandom_range(0, 255));
        rt_pre[2] = 4'($urandom_range(0, 15));
        rt_tap[3] = 3'($urandom_range(0, 7)); rt_seed[3] = 8'($urandom_range(0, 255));
        rt_pre[3] = 4'($urandom_range(0, 15));
        for (int r = 0; r < 4; r++) begin
            logic [7:0] l;
            logic [7:0] d;
            int pe;
            load_msg(1);
            launch(rt_tap[r], rt_seed[r], rt_pre[r]);
            wait_done("rt", cyc);
            pe = (rt_pre[r] < 4'd9) ? 9 : int'(rt_pre[r]);
            $display("run rt%0d: tap=%0d seed=%02h pre=%0d done after %0d cycles",
                     r, rt_tap[r], rt_seed[r], rt_pre[r], cyc);
            check($sformatf("rt%0d_cycles", r), 32'(cyc), 32'(128 - pe));
            check($sformatf("rt%0d_reads", r), 32'(rd_cnt), 32'(64 - pe));
            check($sformatf("rt%0d_src_writes", r), 32'(src_wr_cnt), 32'd0);
            l = (rt_seed[r] == 8'd0) ? 8'h01 : rt_seed[r];
            for (int j = 0; j < 64; j++) begin
                d = mem[64 + j] ^ l;
                if (j < pe) check($sformatf("rt%0d_pre%0d", r, j), 32'(d), 32'(SP));
                else check($sformatf("rt%0d_msg%0d", r, j - pe), 32'(d[6:0]),
                           32'(plain[j - pe][6:0]));
                l = step(l, tap_of(rt_tap[r]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
